// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative divider.
package CorePack;

    localparam int XLEN     = 64;
    localparam int DIV_ITER = 64;

    typedef logic [XLEN-1:0] data_t;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_op_enum;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

    // Signed variants treat operands as two's complement.
    function automatic logic is_signed_op(input div_op_enum op);
        return (op == DIV) || (op == REM);
    endfunction

    // Remainder variants return the remainder instead of the quotient.
    function automatic logic is_rem_op(input div_op_enum op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/div_unit_step.sv
// One restoring radix-2 iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor when it fits, record the bit.
module div_step
    import CorePack::*;
(
    input  data_t rem_in,
    input  data_t quo_in,
    input  data_t dvs,
    output data_t rem_out,
    output data_t quo_out
);

    logic [XLEN:0] w_shift;
    logic          w_ge;

    assign w_shift = {rem_in, quo_in[XLEN-1]};
    assign w_ge    = (w_shift >= {1'b0, dvs});

    // When the subtraction happens the difference is below the divisor,
    // so a 64-bit wrap-around subtract yields the exact value.
    assign rem_out = w_ge ? (w_shift[XLEN-1:0] - dvs) : w_shift[XLEN-1:0];
    assign quo_out = {quo_in[XLEN-2:0], w_ge};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 64-bit integer divider (DIV/DIVU/REM/REMU).
// Magnitudes are divided by a restoring loop, signs are fixed up at the end;
// divide-by-zero and signed overflow bypass the loop entirely.
module div_unit
    import CorePack::*;
(
    input  logic       clk,
    input  logic       rst,
    input  data_t      a,
    input  data_t      b,
    input  div_op_enum div_op,
    input  logic       start,
    input  logic       flush,
    output logic       busy,
    output logic       done,
    output data_t      result
);

    localparam data_t MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e r_state;
    div_state_e w_state_next;

    div_op_enum r_op;
    data_t      r_rem;
    data_t      r_quo;
    data_t      r_dvs;
    logic [6:0] r_cnt;
    logic       r_neg_q;
    logic       r_neg_r;
    data_t      r_result;

    // Operand decode, evaluated against the live inputs while idle.
    logic  w_a_neg;
    logic  w_b_neg;
    data_t w_a_mag;
    data_t w_b_mag;
    logic  w_div_zero;
    logic  w_overflow;
    logic  w_special;
    data_t w_special_res;

    assign w_a_neg    = is_signed_op(div_op) && a[XLEN-1];
    assign w_b_neg    = is_signed_op(div_op) && b[XLEN-1];
    assign w_a_mag    = w_a_neg ? (~a + 1'b1) : a;
    assign w_b_mag    = w_b_neg ? (~b + 1'b1) : b;
    assign w_div_zero = (b == '0);
    assign w_overflow = is_signed_op(div_op) && (a == MIN_NEG) && (b == '1);
    assign w_special  = w_div_zero || w_overflow;

    // Divide-by-zero: quotient all ones, remainder is the dividend.
    // Overflow: quotient is the dividend, remainder zero.
    assign w_special_res = w_div_zero ? (is_rem_op(div_op) ? a : '1)
                                      : (is_rem_op(div_op) ? '0 : a);

    // Iteration datapath and final sign fix-up.
    data_t w_rem_next;
    data_t w_quo_next;
    data_t w_quo_fix;
    data_t w_rem_fix;
    data_t w_final;
    logic  w_last;

    div_step u_step (
        .rem_in  (r_rem),
        .quo_in  (r_quo),
        .dvs     (r_dvs),
        .rem_out (w_rem_next),
        .quo_out (w_quo_next)
    );

    assign w_last    = (r_cnt == 7'(DIV_ITER - 1));
    assign w_quo_fix = r_neg_q ? (~w_quo_next + 1'b1) : w_quo_next;
    assign w_rem_fix = r_neg_r ? (~w_rem_next + 1'b1) : w_rem_next;
    assign w_final   = is_rem_op(r_op) ? w_rem_fix : w_quo_fix;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; flush overrides every other transition.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = w_special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (flush) begin
            w_state_next = S_IDLE;
        end
    end

    // Operand latch, iteration state and result register; a flush freezes
    // everything so the previous result stays visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= DIV;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else if (!flush) begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= div_op;
                        r_rem   <= '0;
                        r_quo   <= w_a_mag;
                        r_dvs   <= w_b_mag;
                        r_cnt   <= '0;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        if (w_special) begin
                            r_result <= w_special_res;
                        end
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_next;
                    r_quo <= w_quo_next;
                    r_cnt <= r_cnt + 7'd1;
                    if (w_last) begin
                        r_result <= w_final;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);
    assign result = r_result;

endmodule

// File: tb/tb_div_unit.sv
// Directed checks for div_unit: latency, results, special cases,
// ignored restarts, flush and reset abort.
module tb_div_unit;
    import CorePack::*;

    logic       clk;
    logic       rst;
    data_t      a;
    data_t      b;
    div_op_enum div_op;
    logic       start;
    logic       flush;
    logic       busy;
    logic       done;
    data_t      result;

    int errors = 0;
    int checks = 0;

    div_unit dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .div_op (div_op),
        .start  (start),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op at the current negedge (cycle T) and follow it to done.
    // restart_at > 0 re-asserts start with other operands in that cycle.
    task automatic run_op(input string tag, input div_op_enum op, input data_t av,
                          input data_t bv, input data_t exp_res, input int exp_lat,
                          input int restart_at);
        int lat;
        int busy_cycles;
        lat = -1;
        busy_cycles = 0;
        div_op = op;
        a = av;
        b = bv;
        start = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cycles++;
            if (done) begin
                lat = k;
                break;
            end
            if (k == restart_at) begin
                a = 64'd9;
                b = 64'd3;
                div_op = DIVU;
                start = 1'b1;
            end
        end
        $display("op %s: a=%h b=%h result=%h latency=%0d", tag, av, bv, result, lat);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " busy cycles"}, 64'(busy_cycles), 64'(exp_lat));
        check({tag, " result"}, result, exp_res);
        @(negedge clk);
        check({tag, " single done"}, 64'(done), 64'd0);
        check({tag, " result held"}, result, exp_res);
    endtask

    initial begin : stim
        int   t;
        logic saw_done;

        rst = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        a = '0;
        b = '0;
        div_op = DIV;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset result", result, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("DIVU 100/7", DIVU, 64'd100, 64'd7, 64'd14, 65, 0);
        run_op("REMU 100/7", REMU, 64'd100, 64'd7, 64'd2, 65, 0);
        run_op("DIV -7/2", DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
        run_op("REM -7/2", REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
        run_op("DIV 7/-2", DIV, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
        run_op("DIVU 5/0", DIVU, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        run_op("REM 5/0", REM, 64'd5, 64'd0, 64'd5, 1, 0);
        run_op("DIV ovf", DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 1, 0);
        run_op("REM ovf", REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0);
        run_op("DIVU max/1", DIVU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
        run_op("REMU max/16", REMU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 64'd15, 65, 0);
        run_op("DIVU 100/7 restart ignored", DIVU, 64'd100, 64'd7, 64'd14, 65, 5);

        // Flush in cycle T+10 kills the op; a new op starts in T+11.
        saw_done = 1'b0;
        div_op = DIVU;
        a = 64'd100;
        b = 64'd7;
        start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) saw_done = 1'b1;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        $display("flush: busy=%0b done=%0b result=%h", busy, done, result);
        check("flush no done", 64'(saw_done), 64'd0);
        check("flush busy", 64'(busy), 64'd0);
        check("flush done", 64'(done), 64'd0);
        check("flush result kept", result, 64'd14);
        run_op("DIVU 9/3 after flush", DIVU, 64'd9, 64'd3, 64'd3, 65, 0);

        // Restart attempt at T+5, reset at T+20: no done, outputs cleared.
        saw_done = 1'b0;
        div_op = DIV;
        a = 64'd100;
        b = 64'd7;
        start = 1'b1;
        t = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            t = k;
            start = (k == 5);
            if (k == 5) begin
                a = 64'd50;
                b = 64'd5;
            end
            if (done) saw_done = 1'b1;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("reset abort after %0d cycles: busy=%0b done=%0b result=%h", t, busy, done, result);
        check("rst abort no done", 64'(saw_done), 64'd0);
        check("rst abort busy", 64'(busy), 64'd0);
        check("rst abort done", 64'(done), 64'd0);
        check("rst abort result", result, 64'd0);
        @(negedge clk);
        check("rst abort idle done", 64'(done), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
